fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Sequences instruction fetch: owns the program counter and issues one request at a time to the instruction memory over a req/ack handshake.
- Buffers returned instructions in a 2-entry FIFO and presents them to decode with a valid/ready handshake.
- Handles branch/jump redirects, including flushing a response that is still in flight.
- Sits between the PC/instruction-memory pair and the decode stage; replaces the free-running PC+4 loop.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- redirect_valid  input  1  one-cycle pulse: redirect fetch to redirect_pc.
- redirect_pc  input  64  redirect target; bits [1:0] are ignored and forced to 0.
- imem_req  output  1  fetch request to instruction memory (registered).
- imem_addr  output  64  fetch address (registered); stable while imem_req=1.
- imem_ack  input  1  memory has data; valid only while imem_req=1.
- imem_rdata  input  32  instruction word; valid with imem_ack.
- if_valid  output  1  buffer head valid.
- if_pc  output  64  PC of buffer head.
- if_instr  output  32  instruction at buffer head.
- if_ready  input  1  decode accepts the head this cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_q=RESET_PC, state=BOOT, FIFO count=0.
  - imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0.
- States: BOOT, FETCH, HOLD, FLUSH.
  - BOOT: first clock after reset release goes to FETCH with imem_req=1, imem_addr=pc_q.
  - FETCH: exactly one request is outstanding. imem_req and imem_addr are held until the rising edge where imem_ack=1. ack in the first req cycle is legal, giving a 1-cycle fetch.
  - On ack in FETCH:
    - push {pc_q, imem_rdata} into the FIFO.
    - pc_q <= pc_q + PC_STEP (mod 2^64; wraps from FFFF_FFFF_FFFF_FFFC to 0).
    - if count_next<2: stay in FETCH and issue the next request in the following cycle with the new address (back-to-back, 1 fetch/cycle max).
    - else: go to HOLD with imem_req=0.
  - HOLD: no request. Go to FETCH (imem_req=1) in the cycle after count_next<2.
  - FLUSH: a redirect arrived while a request was outstanding. Keep imem_req and the old imem_addr until ack, then discard the data (no push). Next state is FETCH at the new pc_q.
- Redirect (highest priority):
  - FIFO is cleared on the same edge; if_valid=0 in the next cycle.
  - pc_q <= {redirect_pc[63:2],2'b00}.
  - From BOOT or HOLD, or from FETCH with ack in the same cycle (that data is discarded): go to FETCH with the new address next cycle.
  - From FETCH without ack: go to FLUSH.
  - Redirect while in FLUSH: update pc_q to the latest target and stay in FLUSH.
- FIFO:
  - Depth 2; if_valid=(count!=0); if_pc and if_instr come from the head entry.
  - Pop on if_valid && if_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Pop and redirect in the same cycle: the pop counts as consumed, and the FIFO is cleared anyway.
  - No push ever occurs when full; this is guaranteed by HOLD.
- Outputs:
  - if_pc and if_instr are held stable while if_valid && !if_ready.
  - imem_addr changes only when imem_req=0 or on the edge where ack is taken.
- imem_ack while imem_req=0 is ignored.
- Reset asserted mid-transaction: everything returns to reset values immediately. Any late ack is ignored because imem_req=0.

Test Plan:
- Reset release, RESET_PC=0, memory acks every req cycle, if_ready=1 -> imem_addr 0,4,8,C on consecutive cycles; if_pc 0,4,8 delivered back-to-back; if_valid first high 2 cycles after release.
- if_ready=0 with 1-cycle memory -> after 2 acks imem_req=0 (HOLD), if_pc=0 held; raise if_ready -> pops 0,4, then fetch of 8 resumes with no lost or duplicated PC.
- Memory ack delayed 3 cycles, redirect_pc=0x1003 pulsed in the first req cycle -> imem_addr stays at the old value until ack; that data is never presented; next imem_addr=0x1000; first if_pc=0x1000.
- Redirect to 0x200 in the same cycle as ack and pop with FIFO holding 2 entries -> next cycle if_valid=0, count=0, imem_addr=0x200; stale entries never appear.
- Redirect to 0xFFFF_FFFF_FFFF_FFF8 -> fetched PCs ...FFF8, ...FFFC, then 0x0 (wrap).
- rst low while in FLUSH with ack pending -> outputs at reset values immediately; ack asserted during reset ignored; after release first imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one imem request at a time,
// buffers responses in a 2-entry FIFO for decode, and handles redirect flushes.
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, FLUSH} state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_ent_t;

  state_t      state_q;
  logic [63:0] pc_q;
  logic        req_q;
  logic [63:0] addr_q;
  fetch_ent_t  ent_q [2];
  logic [1:0]  count_q;

  logic        ack_take;
  logic        pop;
  logic        push;
  logic [1:0]  count_d;
  logic [1:0]  wr_pos;
  logic [63:0] pc_inc;
  logic [63:0] redir_pc;
  logic        redir_pc_unused;

  // Ack only means something while a request is actually on the bus.
  assign ack_take = req_q && imem_ack;
  assign pop      = (count_q != 2'd0) && if_ready;
  assign push     = (state_q == FETCH) && ack_take && !redirect_valid;
  assign count_d  = count_q - {1'b0, pop} + {1'b0, push};
  assign wr_pos   = count_q - {1'b0, pop};
  assign pc_inc   = pc_q + 64'(PC_STEP);
  assign redir_pc = {redirect_pc[63:2], 2'b00};
  assign redir_pc_unused = ^redirect_pc[1:0];

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_valid  = (count_q != 2'd0);
  assign if_pc     = ent_q[0].pc;
  assign if_instr  = ent_q[0].instr;

  // FIFO storage: entry 0 is always the head; pop shifts entry 1 down.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      count_q  <= 2'd0;
    end else if (redirect_valid) begin
      count_q <= 2'd0;
    end else begin
      if (pop)
        ent_q[0] <= ent_q[1];
      if (push) begin
        if (wr_pos[0]) ent_q[1] <= '{pc: pc_q, instr: imem_rdata};
        else           ent_q[0] <= '{pc: pc_q, instr: imem_rdata};
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redir_pc;
      // An un-acked request must still complete on the bus before we can reissue.
      if ((state_q == FETCH || state_q == FLUSH) && !ack_take) begin
        state_q <= FLUSH;
      end else begin
        state_q <= FETCH;
        req_q   <= 1'b1;
        addr_q  <= redir_pc;
      end
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
          addr_q  <= pc_q;
        end
        FETCH: begin
          if (ack_take) begin
            pc_q   <= pc_inc;
            addr_q <= pc_inc;
            if (count_d < 2'd2) begin
              req_q <= 1'b1;
            end else begin
              state_q <= HOLD;
              req_q   <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (count_d < 2'd2) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
          end
        end
        FLUSH: begin
          if (ack_take) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
          end
        end
        default: begin
          state_q <= BOOT;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
